// File: rtl/impact_sram_pkg.sv
// Shared types and bit positions for the IMPACT SRAM head access sequencer.
package impact_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  localparam int NORTH_SEL_LSB = 0;
  localparam int NORTH_SEL_W   = 10;
  localparam int NORTH_PRE     = 12;
  localparam int NORTH_RDEN    = 13;
  localparam int NORTH_WREN    = 14;

  localparam int IMPACT_WORDS  = 1024;
  localparam int IMPACT_DATA_W = 32;

  localparam int PHASE_CNT_W   = 4;

endpackage

// File: rtl/impact_phase_timer.sv
// Loadable 4-bit down-counter that times the precharge and access phases.
module impact_phase_timer
  import impact_sram_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [PHASE_CNT_W-1:0] load_val_i,
  output logic                   zero_o
);

  logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at zero so the flag stays stable while the sequencer is idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/impact_sram_sequencer.sv
// Turns one valid/ready read or write request into the IMPACT head's
// select / precharge / enable pin phases and returns a one-cycle response.
module impact_sram_sequencer
  import impact_sram_pkg::*;
#(
  parameter int PRE_CYCLES    = 2,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [NORTH_SEL_W-1:0]   req_addr,
  input  logic [IMPACT_DATA_W-1:0] req_wdata,
  output logic                     rsp_valid,
  output logic [IMPACT_DATA_W-1:0] rsp_rdata,
  output logic [31:0]              north,
  output logic [IMPACT_DATA_W-1:0] east,
  input  logic [IMPACT_DATA_W-1:0] south
);

  if (PRE_CYCLES < 1 || PRE_CYCLES > 15) begin : g_bad_pre
    $error("impact_sram_sequencer: PRE_CYCLES must be in 1..15");
  end
  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access
    $error("impact_sram_sequencer: ACCESS_CYCLES must be in 1..15");
  end

  localparam logic [PHASE_CNT_W-1:0] PRE_LOAD    = PHASE_CNT_W'(PRE_CYCLES - 1);
  localparam logic [PHASE_CNT_W-1:0] ACCESS_LOAD = PHASE_CNT_W'(ACCESS_CYCLES - 1);

  state_e                   state_q, state_d;
  logic                     we_q, we_d;
  logic [NORTH_SEL_W-1:0]   addr_q, addr_d;
  logic [IMPACT_DATA_W-1:0] wdata_q, wdata_d;
  logic [IMPACT_DATA_W-1:0] rdata_q, rdata_d;
  logic [31:0]              north_q, north_d;
  logic                     rsp_valid_q, rsp_valid_d;

  logic                     handshake;
  logic                     tmr_load;
  logic [PHASE_CNT_W-1:0]   tmr_load_val;
  logic                     tmr_zero;

  impact_phase_timer u_phase_timer (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  assign req_ready = (state_q == ST_IDLE) & ~wb_rst_i;
  assign handshake = req_valid & req_ready;

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d      = ST_PRECHARGE;
          tmr_load     = 1'b1;
          tmr_load_val = PRE_LOAD;
        end
      end
      ST_PRECHARGE: begin
        if (tmr_zero) begin
          state_d      = ST_ACCESS;
          tmr_load     = 1'b1;
          tmr_load_val = ACCESS_LOAD;
        end
      end
      ST_ACCESS: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    we_d    = handshake ? req_we    : we_q;
    addr_d  = handshake ? req_addr  : addr_q;
    wdata_d = handshake ? req_wdata : wdata_q;

    north_d = '0;
    north_d[NORTH_SEL_LSB +: NORTH_SEL_W] = addr_d;
    north_d[NORTH_PRE]  = (state_d == ST_PRECHARGE);
    north_d[NORTH_RDEN] = (state_d == ST_ACCESS) & ~we_d;
    north_d[NORTH_WREN] = (state_d == ST_ACCESS) &  we_d;

    rsp_valid_d = (state_d == ST_DONE);

    rdata_d = rdata_q;
    if ((state_q == ST_ACCESS) && tmr_zero && !we_q) begin
      rdata_d = south;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      north_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      north_q     <= north_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign north     = north_q;
  assign east      = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: doc/impact_sram_sequencer.md
# impact_sram_sequencer

Access sequencer that drives the IMPACT SRAM head's control bus from a simple valid/ready request port. It converts one read or write request into the head's pin-level phases: address select, precharge, then read/write enable. Read data is captured from the head's `South` output and returned as a one-cycle response. It sits between the user-side logic (Wishbone bridge or test engine) and the head's `North`/`East`/`South` ports.

## Interface
- `PRE_CYCLES`, default 2: precharge phase length in cycles; legal range 1..15.
- `ACCESS_CYCLES`, default 2: read/write enable phase length in cycles; legal range 1..15.
- `wb_clk_i`  in  1  sole clock; all logic is on the rising edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer accepts a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  10  word address, 0..1023.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle completion pulse, for both read and write.
- `rsp_rdata`  out  32  read data; valid when `rsp_valid` is high after a read.
- `north`  out  32  head control bus:
  - [9:0] word select.
  - [12] PRE.
  - [13] ReadEn.
  - [14] WriteEn.
  - All other bits are 0.
- `east`  out  32  head data-in bus.
- `south`  in  32  head data-out bus.

## Operation
- **States:** IDLE, PRECHARGE, ACCESS, DONE.
- **IDLE**
  - `req_ready = (state==IDLE) & ~wb_rst_i`.
  - A handshake is `req_valid & req_ready`. On a handshake, latch `req_we`, `req_addr` and `req_wdata`, load the phase counter with `PRE_CYCLES-1`, and go to PRECHARGE.
- **PRECHARGE**
  - `north[9:0]` = latched address; `north[12]=1`; `north[13]=0`; `north[14]=0`.
  - The counter decrements each cycle. At 0, load `ACCESS_CYCLES-1` and go to ACCESS.
- **ACCESS**
  - `north[12]=0`.
  - Read: `north[13]=1`. Write: `north[14]=1`.
  - The counter decrements each cycle. At 0, go to DONE.
  - Read only: on the last ACCESS cycle, register `south` into `rsp_rdata`.
- **DONE**
  - All enables are 0 (recovery cycle); `rsp_valid=1` for exactly this cycle.
  - Go to IDLE next cycle.
- **`east`:** holds the latched write data from the handshake until the next handshake; the data is ignored by the head on reads.
- **`north[9:0]`:** holds the last address in IDLE. The head's decoder is always one-hot, so the address must not glitch while an enable is high.
- **`rsp_rdata`:** holds its value until the next read capture. Writes leave it unchanged.
- **Invariants, every cycle:**
  - At most one of PRE, ReadEn, WriteEn is high.
  - ReadEn and WriteEn are never both high.
  - The address does not change between the handshake and DONE.
- **Reset:** all outputs go to 0 on the next edge. This includes `north`, `east`, `rsp_rdata`, `rsp_valid` and the state, which returns to IDLE.
- **Reset mid-transaction:** the request is aborted. No `rsp_valid` is issued for it, and no enable remains high after the reset edge.
- **`req_valid` outside IDLE:** ignored. The requester must hold the request until `req_ready` is high.
- **Out-of-range parameters:** an elaboration-time error; the RTL must not silently clamp.

## Timing
- Handshake edge = cycle 0.
- PRE is high in cycles 1..P; the enable is high in cycles P+1..P+A; DONE (`rsp_valid`) is cycle P+A+1. Here P = `PRE_CYCLES` and A = `ACCESS_CYCLES`.
- `req_ready` returns high in cycle P+A+2.
- Defaults: `rsp_valid` in cycle 5; maximum throughput is one request per 6 cycles.
- Read data is sampled in cycle P+A and presented from cycle P+A+1.
- All outputs are registered. `req_ready` is the only output with combinational dependence, and it depends only on the state and `wb_rst_i`.

## Structure
- **Shared package `impact_sram_pkg`:**
  - State enum.
  - Bit-position constants `NORTH_SEL_LSB=0`, `NORTH_SEL_W=10`, `NORTH_PRE=12`, `NORTH_RDEN=13`, `NORTH_WREN=14`.
  - `IMPACT_WORDS=1024`, `IMPACT_DATA_W=32`.
- **Sub-module `impact_phase_timer`:** 4-bit loadable down-counter with `load`, `load_val` and `zero` flag, reused for both phases.
- **FSM, request latch and output registers:** live in `impact_sram_sequencer`.

## Test plan
- **Reset:** reset 3 cycles.
  - During reset: `north`, `east`, `rsp_valid` and `rsp_rdata` are all 0.
  - After release: `req_ready=1` in the first post-reset cycle.
- **Write:** write `addr=10'h155`, `wdata=32'hDEADBEEF`.
  - `north=32'h00001155` in cycles 1–2.
  - `north=32'h00004155` in cycles 3–4.
  - `north=32'h00000155` in cycle 5.
  - `east=32'hDEADBEEF`.
  - `rsp_valid` high only in cycle 5.
- **Read:** read `addr=10'h3FF` with the `south` model returning `32'hA5A5_0001`.
  - ReadEn is high in cycles 3–4.
  - `rsp_rdata=32'hA5A50001` with `rsp_valid` in cycle 5.
  - `req_ready` returns high in cycle 6.
- **Back-to-back:** hold `req_valid` high continuously for 3 reads.
  - Handshakes occur in cycles 0, 6 and 12.
  - The PRE/ReadEn/WriteEn exclusivity assertion never fires.
- **Reset mid-transaction:** assert `wb_rst_i` in cycle 3 of a write.
  - `north[14]=0` from cycle 4 onward.
  - No `rsp_valid` for the aborted write.
  - The next request completes normally.
- **Parameter sweep:** `PRE_CYCLES=1`, `ACCESS_CYCLES=4`; read.
  - PRE high in cycle 1 only.
  - ReadEn high in cycles 2–5.
  - `rsp_valid` in cycle 6.
